snn_layer_ctrl: RTL and testbench

SNN_LAYER_CTRL -- requirements
Module: snn_layer_ctrl

---
 rtl/snn_pkg.sv | 27 ++
 rtl/snn_act_sat.sv | 24 ++
 rtl/snn_layer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_snn_layer_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared sizing, widths and FSM encoding for the two-layer SNN classifier controller.
// Pure declarations; no logic, no latency, no backpressure.
package snn_pkg;

  localparam int N_IN   = 784;
  localparam int N_HID  = 32;
  localparam int N_OUT  = 10;

  localparam int ACC_W  = 26;
  localparam int LUT_AW = 11;

  typedef enum logic [3:0] {
    IDLE,
    L1_CLR,
    L1_MAC,
    L1_DRAIN,
    L1_ACT,
    L1_WR,
    L2_CLR,
    L2_MAC,
    L2_DRAIN,
    L2_ACT,
    L2_WR,
    DONE
  } state_t;

endpackage

// File: rtl/snn_act_sat.sv
// Maps the final MAC accumulator onto a saturated, offset-binary activation LUT address.
// Latency: purely combinational; backpressure: none.
module snn_act_sat
  import snn_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  output logic [LUT_AW-1:0] lut_addr
);

  logic [LUT_AW-1:0] sat;

  // Clamp to the signed 11-bit window acc[17:7]; the +0x400 turns it into a 0-based table index.
  always_comb begin
    if (!acc[ACC_W-1] && (|acc[24:17])) begin
      sat = 11'h3FF;
    end else if (acc[ACC_W-1] && !(&acc[24:17])) begin
      sat = 11'h400;
    end else begin
      sat = acc[17:7];
    end
    lut_addr = sat + 11'h400;
  end

endmodule

// File: rtl/snn_layer_ctrl.sv
// Sequences MAC, activation and write-back for both SNN layers, then argmaxes the outputs.
// Latency: start-accept to done = 25577 cycles at default sizes; start is ignored while busy.
module snn_layer_ctrl #(
  parameter int N_IN  = snn_pkg::N_IN,
  parameter int N_HID = snn_pkg::N_HID,
  parameter int N_OUT = snn_pkg::N_OUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic [3:0]         digit,
  output logic [9:0]         addr_input_unit,
  output logic [14:0]        addr_hidden_weight,
  output logic [8:0]         addr_output_weight,
  output logic [4:0]         addr_hidden_unit,
  output logic [3:0]         addr_output_unit,
  output logic               sel_layer,
  output logic               mac_clr_n,
  output logic               mac_en,
  input  logic signed [25:0] acc,
  output logic [10:0]        lut_addr,
  input  logic [7:0]         lut_q,
  output logic               we_hidden,
  output logic               we_output
);

  import snn_pkg::*;

  localparam logic [9:0]  I_LAST  = 10'(N_IN - 1);
  localparam logic [4:0]  J_LAST  = 5'(N_HID - 1);
  localparam logic [4:0]  H_LAST  = 5'(N_HID - 1);
  localparam logic [3:0]  O_LAST  = 4'(N_OUT - 1);
  localparam logic [14:0] HW_STEP = 15'(N_IN);
  localparam logic [8:0]  OW_STEP = 9'(N_HID);

  state_t state, state_nxt;

  logic [9:0]  i_cnt;
  logic [4:0]  j_cnt;
  logic [4:0]  h_cnt;
  logic [3:0]  o_cnt;
  logic [14:0] hw_base;
  logic [8:0]  ow_base;
  logic [7:0]  max_q;
  logic [3:0]  idx_q;
  logic [3:0]  digit_q;
  logic        mac_en_q;
  logic [LUT_AW-1:0] sat_addr;

  snn_act_sat u_act_sat (
    .acc      (acc),
    .lut_addr (sat_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = L1_CLR;
      L1_CLR:   state_nxt = L1_MAC;
      L1_MAC:   if (i_cnt == I_LAST) state_nxt = L1_DRAIN;
      L1_DRAIN: state_nxt = L1_ACT;
      L1_ACT:   state_nxt = L1_WR;
      L1_WR:    state_nxt = (h_cnt == H_LAST) ? L2_CLR : L1_CLR;
      L2_CLR:   state_nxt = L2_MAC;
      L2_MAC:   if (j_cnt == J_LAST) state_nxt = L2_DRAIN;
      L2_DRAIN: state_nxt = L2_ACT;
      L2_ACT:   state_nxt = L2_WR;
      L2_WR:    state_nxt = (o_cnt == O_LAST) ? DONE : L2_CLR;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Addresses are forced to zero outside the state that owns them so idle buses stay quiet.
  always_comb begin
    done               = (state == DONE);
    busy               = (state != IDLE) && (state != DONE);
    sel_layer          = state inside {L2_CLR, L2_MAC, L2_DRAIN, L2_ACT, L2_WR};
    mac_clr_n          = !((state == L1_CLR) || (state == L2_CLR));
    mac_en             = mac_en_q;
    we_hidden          = (state == L1_WR);
    we_output          = (state == L2_WR);
    digit              = digit_q;
    addr_input_unit    = '0;
    addr_hidden_weight = '0;
    addr_output_weight = '0;
    addr_hidden_unit   = '0;
    addr_output_unit   = '0;
    lut_addr           = '0;
    unique case (state)
      L1_MAC: begin
        addr_input_unit    = i_cnt;
        addr_hidden_weight = hw_base + {5'd0, i_cnt};
      end
      L1_WR:  addr_hidden_unit = h_cnt;
      L2_MAC: begin
        addr_hidden_unit   = j_cnt;
        addr_output_weight = ow_base + {4'd0, j_cnt};
      end
      L2_WR:  addr_output_unit = o_cnt;
      L1_ACT, L2_ACT: lut_addr = sat_addr;
      default: ;
    endcase
  end

  // Operand data returns one cycle after its address, so enable trails the MAC state by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en_q <= 1'b0;
    end else begin
      mac_en_q <= (state == L1_MAC) || (state == L2_MAC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt   <= '0;
      j_cnt   <= '0;
      h_cnt   <= '0;
      o_cnt   <= '0;
      hw_base <= '0;
      ow_base <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      digit_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            h_cnt   <= '0;
            o_cnt   <= '0;
            hw_base <= '0;
            ow_base <= '0;
          end
        end
        L1_CLR, L2_CLR: begin
          i_cnt <= '0;
          j_cnt <= '0;
        end
        L1_MAC: if (i_cnt != I_LAST) i_cnt <= i_cnt + 10'd1;
        L2_MAC: if (j_cnt != J_LAST) j_cnt <= j_cnt + 5'd1;
        L1_WR: begin
          if (h_cnt == H_LAST) begin
            h_cnt   <= '0;
            hw_base <= '0;
          end else begin
            h_cnt   <= h_cnt + 5'd1;
            hw_base <= hw_base + HW_STEP;
          end
        end
        L2_WR: begin
          // Strict compare keeps the lowest index on ties; output 0 always seeds the running max.
          if ((o_cnt == 4'd0) || (lut_q > max_q)) begin
            max_q <= lut_q;
            idx_q <= o_cnt;
          end
          if (o_cnt == O_LAST) begin
            o_cnt   <= '0;
            ow_base <= '0;
          end else begin
            o_cnt   <= o_cnt + 4'd1;
            ow_base <= ow_base + OW_STEP;
          end
        end
        DONE: digit_q <= idx_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_layer_ctrl.sv
// Scoreboarded bench for snn_layer_ctrl: drives acc/lut_q per neuron and checks timing, addresses and argmax.
module tb_snn_layer_ctrl;

  localparam int N_IN     = 784;
  localparam int N_HID    = 32;
  localparam int N_OUT    = 10;
  localparam int DONE_CYC = 25577;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               done;
  logic               busy;
  logic [3:0]         digit;
  logic [9:0]         addr_input_unit;
  logic [14:0]        addr_hidden_weight;
  logic [8:0]         addr_output_weight;
  logic [4:0]         addr_hidden_unit;
  logic [3:0]         addr_output_unit;
  logic               sel_layer;
  logic               mac_clr_n;
  logic               mac_en;
  logic signed [25:0] acc;
  logic [10:0]        lut_addr;
  logic [7:0]         lut_q;
  logic               we_hidden;
  logic               we_output;

  always #5 clk = ~clk;

  snn_layer_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .done               (done),
    .busy               (busy),
    .digit              (digit),
    .addr_input_unit    (addr_input_unit),
    .addr_hidden_weight (addr_hidden_weight),
    .addr_output_weight (addr_output_weight),
    .addr_hidden_unit   (addr_hidden_unit),
    .addr_output_unit   (addr_output_unit),
    .sel_layer          (sel_layer),
    .mac_clr_n          (mac_clr_n),
    .mac_en             (mac_en),
    .acc                (acc),
    .lut_addr           (lut_addr),
    .lut_q              (lut_q),
    .we_hidden          (we_hidden),
    .we_output          (we_output)
  );

  int checks   = 0;
  int failures = 0;

  logic [25:0] acc_tab [8];
  logic [10:0] lut_tab [8];
  logic [7:0]  out_tab [N_OUT];

  logic [10:0] exp_lut_q [$];
  logic [3:0]  exp_digit_q [$];

  int r_done_at, r_wh, r_wo, r_hw_cnt, r_ow_cnt;
  int r_addr_errs, r_len_errs, r_seq_errs, r_clr_errs;
  logic r_busy1;

  // One classification; restart_at injects a stray start, rst_at aborts with reset (-1 disables).
  task automatic run_classify(input int restart_at, input int rst_at);
    int cyc, mac_left, run_len, hw_exp, ow_exp, i_exp, j_exp, nidx;
    logic layer, prev_en;
    logic [10:0] e_lut;
    logic [3:0]  e_dig;
    r_done_at = -1; r_wh = 0; r_wo = 0; r_hw_cnt = 0; r_ow_cnt = 0;
    r_addr_errs = 0; r_len_errs = 0; r_seq_errs = 0; r_clr_errs = 0; r_busy1 = 1'b0;
    cyc = 0; mac_left = 0; run_len = 0; hw_exp = 0; ow_exp = 0; i_exp = 0; j_exp = 0;
    layer = 1'b0; prev_en = 1'b0; nidx = 0;
    acc = acc_tab[0];
    exp_lut_q.push_back(lut_tab[0]);
    start = 1'b1;
    while (cyc < DONE_CYC + 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start   = 1'b0;
        r_busy1 = busy;
      end
      if (cyc == restart_at) start = 1'b1;
      else if (cyc == restart_at + 1) start = 1'b0;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        break;
      end
      if (mac_left > 0) begin
        if (!layer) begin
          if (addr_hidden_weight != 15'(hw_exp) || addr_input_unit != 10'(i_exp)) r_addr_errs++;
          hw_exp++; i_exp++;
        end else begin
          if (addr_output_weight != 9'(ow_exp) || addr_hidden_unit != 5'(j_exp)) r_addr_errs++;
          ow_exp++; j_exp++;
        end
        mac_left--;
      end
      if (!mac_clr_n) begin
        if (mac_en) r_clr_errs++;
        layer    = sel_layer;
        mac_left = sel_layer ? N_HID : N_IN;
        i_exp    = 0;
        j_exp    = 0;
      end
      if (mac_en) run_len++;
      if (prev_en && !mac_en) begin
        if (run_len != (sel_layer ? N_HID : N_IN)) r_len_errs++;
        run_len = 0;
        checks++;
        if (exp_lut_q.size() == 0) begin
          failures++;
          $display("FAIL act_lut: unexpected ACT at cycle %0d, lut_addr=%h, no expectation queued", cyc, lut_addr);
        end else begin
          e_lut = exp_lut_q.pop_front();
          if (lut_addr !== e_lut) begin
            failures++;
            $display("FAIL act_lut: cycle %0d lut_addr=%h expected %h", cyc, lut_addr, e_lut);
          end
        end
      end
      prev_en = mac_en;
      if (we_hidden && we_output) r_seq_errs++;
      if (we_hidden) begin
        if (addr_hidden_unit != 5'(r_wh)) r_seq_errs++;
        r_wh++;
        lut_q = 8'h5A;
      end
      if (we_output) begin
        if (addr_output_unit != 4'(r_wo)) r_seq_errs++;
        lut_q = (r_wo < N_OUT) ? out_tab[r_wo] : 8'h00;
        r_wo++;
      end
      if (we_hidden || we_output) begin
        nidx++;
        if (nidx < N_HID + N_OUT) begin
          acc = acc_tab[nidx % 8];
          exp_lut_q.push_back(lut_tab[nidx % 8]);
        end
      end
      if (done) begin
        r_done_at = cyc;
        r_hw_cnt  = hw_exp;
        r_ow_cnt  = ow_exp;
        @(negedge clk);
        checks++;
        if (exp_digit_q.size() == 0) begin
          failures++;
          $display("FAIL digit: done seen with no expected digit queued, digit=%0d", digit);
        end else begin
          e_dig = exp_digit_q.pop_front();
          if (digit !== e_dig) begin
            failures++;
            $display("FAIL digit: got %0d expected %0d", digit, e_dig);
          end
        end
        checks++;
        if ({done, busy} !== 2'b00) begin
          failures++;
          $display("FAIL post_done: {done,busy}=%b expected 00", {done, busy});
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; acc = '0; lut_q = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, sel_layer, mac_en, we_hidden, we_output, mac_clr_n} !== 7'b0000001) begin
      failures++;
      $display("FAIL reset_ctrl: {done,busy,sel,mac_en,we_h,we_o,clr_n}=%b expected 0000001",
               {done, busy, sel_layer, mac_en, we_hidden, we_output, mac_clr_n});
    end
    checks++;
    if ({addr_input_unit, addr_hidden_weight, addr_output_weight, addr_hidden_unit, addr_output_unit} !== 43'd0) begin
      failures++;
      $display("FAIL reset_addr: addresses=%h expected 0",
               {addr_input_unit, addr_hidden_weight, addr_output_weight, addr_hidden_unit, addr_output_unit});
    end
    checks++;
    if (lut_addr !== 11'h000) begin
      failures++;
      $display("FAIL reset_lut: lut_addr=%h expected 000", lut_addr);
    end
    checks++;
    if (digit !== 4'd0) begin
      failures++;
      $display("FAIL reset_digit: digit=%0d expected 0", digit);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_full_run_tie_and_busy_start();
    for (int k = 0; k < N_OUT; k++) out_tab[k] = 8'h10;
    out_tab[3] = 8'hC0;
    out_tab[7] = 8'hC0;
    exp_digit_q.push_back(4'd3);
    run_classify(500, -1);
    checks++;
    if (r_done_at != DONE_CYC) begin failures++; $display("FAIL full_latency: done at %0d expected %0d", r_done_at, DONE_CYC); end
    checks++;
    if (r_busy1 !== 1'b1) begin failures++; $display("FAIL busy_cycle1: busy=%b expected 1", r_busy1); end
    checks++;
    if (r_wh != N_HID) begin failures++; $display("FAIL we_hidden_count: %0d expected %0d", r_wh, N_HID); end
    checks++;
    if (r_wo != N_OUT) begin failures++; $display("FAIL we_output_count: %0d expected %0d", r_wo, N_OUT); end
    checks++;
    if (r_hw_cnt != N_IN * N_HID) begin failures++; $display("FAIL hw_addr_span: %0d issued expected %0d", r_hw_cnt, N_IN * N_HID); end
    checks++;
    if (r_ow_cnt != N_HID * N_OUT) begin failures++; $display("FAIL ow_addr_span: %0d issued expected %0d", r_ow_cnt, N_HID * N_OUT); end
    checks++;
    if (r_addr_errs != 0) begin failures++; $display("FAIL mac_addr_seq: %0d bad cycles expected 0", r_addr_errs); end
    checks++;
    if (r_seq_errs != 0) begin failures++; $display("FAIL wr_addr_seq: %0d bad writes expected 0", r_seq_errs); end
    checks++;
    if (r_len_errs != 0) begin failures++; $display("FAIL mac_en_len: %0d bad bursts expected 0", r_len_errs); end
    checks++;
    if (r_clr_errs != 0) begin failures++; $display("FAIL mac_en_in_clr: %0d cycles expected 0", r_clr_errs); end
    checks++;
    if (exp_lut_q.size() != 0) begin failures++; $display("FAIL act_count: %0d ACT cycles missing expected 0", exp_lut_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < N_OUT; k++) out_tab[k] = 8'h40;
    out_tab[0] = 8'hEF;
    out_tab[9] = 8'hF0;
    run_classify(-1, 1000);
    #1;
    checks++;
    if ({done, busy, sel_layer, mac_en, we_hidden, we_output, mac_clr_n} !== 7'b0000001) begin
      failures++;
      $display("FAIL midrst_ctrl: {done,busy,sel,mac_en,we_h,we_o,clr_n}=%b expected 0000001",
               {done, busy, sel_layer, mac_en, we_hidden, we_output, mac_clr_n});
    end
    checks++;
    if ({addr_input_unit, addr_hidden_weight, addr_output_weight, addr_hidden_unit, addr_output_unit, lut_addr} !== 54'd0) begin
      failures++;
      $display("FAIL midrst_addr: addresses=%h expected 0",
               {addr_input_unit, addr_hidden_weight, addr_output_weight, addr_hidden_unit, addr_output_unit, lut_addr});
    end
    checks++;
    if (digit !== 4'd0) begin failures++; $display("FAIL midrst_digit: digit=%0d expected 0", digit); end
    exp_lut_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_digit_q.push_back(4'd9);
    run_classify(-1, -1);
    checks++;
    if (r_done_at != DONE_CYC) begin failures++; $display("FAIL rerun_latency: done at %0d expected %0d", r_done_at, DONE_CYC); end
    checks++;
    if (r_addr_errs != 0 || r_seq_errs != 0) begin
      failures++;
      $display("FAIL rerun_addr: addr_errs=%0d seq_errs=%0d expected 0", r_addr_errs, r_seq_errs);
    end
  endtask

  task automatic test_all_zero();
    for (int k = 0; k < N_OUT; k++) out_tab[k] = 8'h00;
    exp_digit_q.push_back(4'd0);
    run_classify(-1, -1);
    checks++;
    if (r_done_at != DONE_CYC) begin failures++; $display("FAIL zero_latency: done at %0d expected %0d", r_done_at, DONE_CYC); end
  endtask

  initial begin
    acc_tab[0] = 26'h0020000; lut_tab[0] = 11'h7FF;
    acc_tab[1] = 26'h2000000; lut_tab[1] = 11'h000;
    acc_tab[2] = 26'h3FFFF80; lut_tab[2] = 11'h3FF;
    acc_tab[3] = 26'h0000080; lut_tab[3] = 11'h401;
    acc_tab[4] = 26'h0000000; lut_tab[4] = 11'h400;
    acc_tab[5] = 26'h3FFFF00; lut_tab[5] = 11'h3FE;
    acc_tab[6] = 26'h0012340; lut_tab[6] = 11'h646;
    acc_tab[7] = 26'h3FE1000; lut_tab[7] = 11'h020;
    rst_n = 1'b0; start = 1'b0; acc = '0; lut_q = '0;
    @(negedge clk);
    test_reset();
    test_full_run_tie_and_busy_start();
    test_reset_mid_run();
    test_all_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
